// File: rtl/sram_loader_pkg.sv
// sram_loader_pkg
//   Shared types and helpers for the SRAM stream loader.
//   - state_t     : loader FSM states
//   - SUM_W       : checksum width (bytes are zero-extended and summed mod 2^SUM_W)
//   - word_count  : number of SRAM words covering a byte count
//   - lane_of     : byte lane a stream byte index lands in
package sram_loader_pkg;

    localparam int SUM_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        CHECK
    } state_t;

    function automatic int unsigned word_count(input int unsigned len, input int unsigned nb_col);
        return (len + nb_col - 1) / nb_col;
    endfunction

    function automatic int unsigned lane_of(input int unsigned b, input int unsigned nb_col);
        return b % nb_col;
    endfunction

endpackage

// File: rtl/sram_rd_accum.sv
// sram_rd_accum
//   Readback checksum accumulator. Each valid cycle adds the lanes of douta
//   whose byte index (word_idx*NB_COL + lane) falls inside the job length;
//   lanes past the end of the job belong to data we did not write and are
//   ignored.
// Ports
//   clka, rsta  : clock, async active-high reset
//   clear       : zero the accumulator (job start); wins over valid
//   valid       : douta holds the word for word_idx this cycle
//   word_idx    : index of the word being captured, relative to base
//   byte_len    : job length in bytes
//   douta       : SRAM read data
//   rd_sum      : running checksum of the in-range readback bytes
module sram_rd_accum
    import sram_loader_pkg::*;
#(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic                        clka,
    input  logic                        rsta,
    input  logic                        clear,
    input  logic                        valid,
    input  logic [LEN_WIDTH:0]          word_idx,
    input  logic [LEN_WIDTH-1:0]        byte_len,
    input  logic [NB_COL*COL_WIDTH-1:0] douta,
    output logic [SUM_W-1:0]            rd_sum
);

    // Wide enough for word_idx*NB_COL + lane without wrapping.
    localparam int IDX_W = LEN_WIDTH + 3;

    logic [IDX_W-1:0] first_byte;
    logic [SUM_W-1:0] lane_sum;

    assign first_byte = IDX_W'(word_idx) * IDX_W'(NB_COL);

    always_comb begin
        lane_sum = '0;
        for (int lane = 0; lane < NB_COL; lane++) begin
            if ((first_byte + IDX_W'(lane)) < IDX_W'(byte_len)) begin
                lane_sum = lane_sum + SUM_W'(douta[lane*COL_WIDTH +: COL_WIDTH]);
            end
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            rd_sum <= '0;
        end else if (clear) begin
            rd_sum <= '0;
        end else if (valid) begin
            rd_sum <= rd_sum + lane_sum;
        end
    end

endmodule

// File: rtl/sram_stream_loader.sv
// sram_stream_loader
//   Streams bytes into a byte-write SRAM one lane at a time starting at a word
//   base address, then reads the region back and compares a byte checksum of
//   the readback against the checksum of the streamed data.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; done pulses here for one cycle
//   LOAD  | s_ready=1, each accepted byte is written to its lane
//   READ  | one read per covered word, base+k, k=0..W-1
//   DRAIN | no access; capture of the last read word
//   CHECK | compare checksums, publish sum/error, raise done
//
// Ports
//   clka, rsta          : clock (shared with SRAM), async active-high reset
//   start               : job request, sampled in IDLE with base_addr/byte_len
//   s_data/s_valid      : byte stream in; s_ready high only in LOAD
//   busy                : high whenever not IDLE
//   done                : one-cycle end-of-job pulse
//   error, sum          : checksum mismatch and streamed checksum, held until next start
//   addra/dina/wea/ena  : SRAM A-port drive
//   douta               : SRAM read data, one cycle after an enabled read
module sram_stream_loader
    import sram_loader_pkg::*;
#(
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                        clka,
    input  logic                        rsta,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [LEN_WIDTH-1:0]        byte_len,
    input  logic [COL_WIDTH-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [SUM_W-1:0]            sum,
    output logic [ADDR_WIDTH-1:0]       addra,
    output logic [NB_COL*COL_WIDTH-1:0] dina,
    output logic [NB_COL-1:0]           wea,
    output logic                        ena,
    input  logic [NB_COL*COL_WIDTH-1:0] douta
);

    // Word counts need one bit more than the byte length.
    localparam int WC_W = LEN_WIDTH + 1;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  byte_cnt;
    logic [WC_W-1:0]       rd_k;
    logic [WC_W-1:0]       words_left;
    logic [WC_W-1:0]       rd_k_q;
    logic                  rd_pend;
    logic [SUM_W-1:0]      wr_sum;
    logic [SUM_W-1:0]      rd_sum;
    logic                  job_start;
    logic                  hs;

    assign job_start = (state == IDLE) && start;
    assign hs        = (state == LOAD) && s_valid;
    assign busy      = (state != IDLE);

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        ena      = 1'b0;
        wea      = '0;
        addra    = '0;
        dina     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (byte_len == '0) ? CHECK : LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ena   = 1'b1;
                    addra = base_r + ADDR_WIDTH'(byte_cnt / LEN_WIDTH'(NB_COL));
                    wea   = NB_COL'(1) << lane_of(32'(byte_cnt), NB_COL);
                    dina  = {NB_COL{s_data}};
                    if (byte_cnt == len_r - LEN_WIDTH'(1)) begin
                        state_nx = READ;
                    end
                end
            end
            READ: begin
                // Write-first SRAM: reading the word just written is safe.
                ena   = 1'b1;
                addra = base_r + ADDR_WIDTH'(rd_k);
                if (words_left == WC_W'(1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = CHECK;
            end
            CHECK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            base_r     <= '0;
            len_r      <= '0;
            byte_cnt   <= '0;
            rd_k       <= '0;
            words_left <= '0;
            rd_k_q     <= '0;
            rd_pend    <= 1'b0;
            wr_sum     <= '0;
            sum        <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done    <= 1'b0;
            // Read data comes back one cycle later; remember which word it is.
            rd_pend <= (state == READ);
            rd_k_q  <= rd_k;
            if (job_start) begin
                base_r     <= base_addr;
                len_r      <= byte_len;
                byte_cnt   <= '0;
                rd_k       <= '0;
                words_left <= WC_W'(word_count(32'(byte_len), NB_COL));
                wr_sum     <= '0;
                sum        <= '0;
                error      <= 1'b0;
            end
            if (hs) begin
                byte_cnt <= byte_cnt + LEN_WIDTH'(1);
                wr_sum   <= wr_sum + SUM_W'(s_data);
            end
            if (state == READ) begin
                rd_k       <= rd_k + WC_W'(1);
                words_left <= words_left - WC_W'(1);
            end
            if (state == CHECK) begin
                error <= (rd_sum != wr_sum);
                sum   <= wr_sum;
                done  <= 1'b1;
            end
        end
    end

    sram_rd_accum #(
        .NB_COL    (NB_COL),
        .COL_WIDTH (COL_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_rd_accum (
        .clka     (clka),
        .rsta     (rsta),
        .clear    (job_start),
        .valid    (rd_pend),
        .word_idx (rd_k_q),
        .byte_len (len_r),
        .douta    (douta),
        .rd_sum   (rd_sum)
    );

endmodule

// File: tb/tb_sram_stream_loader.sv
// tb_sram_stream_loader
//   Drives loader jobs against a behavioural byte-enable write-first SRAM.
//   Expected memory images, checksums, error flags and done latencies are
//   pushed to queues when a job is driven and popped when done appears.
module tb_sram_stream_loader;

    localparam int NB_COL     = 4;
    localparam int COL_WIDTH  = 8;
    localparam int ADDR_WIDTH = 13;
    localparam int LEN_WIDTH  = 16;

    logic        clka;
    logic        rsta;
    logic        start;
    logic [12:0] base_addr;
    logic [15:0] byte_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] sum;
    logic [12:0] addra;
    logic [31:0] dina;
    logic [3:0]  wea;
    logic        ena;
    logic [31:0] douta;

    int n_vec = 0;
    int n_err = 0;

    initial clka = 1'b0;
    always #5 clka = ~clka;

    sram_stream_loader #(
        .NB_COL     (NB_COL),
        .COL_WIDTH  (COL_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .base_addr (base_addr),
        .byte_len  (byte_len),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .sum       (sum),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .ena       (ena),
        .douta     (douta)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:8191];
    logic [31:0] dout_q = '0;
    logic        corrupt_q = 1'b0;
    int          rd_count = 0;
    logic        corrupt_en = 1'b0;
    int          corrupt_at = 0;
    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
        return w;
    endfunction

    always @(posedge clka) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ena) begin
            mem[addra] <= merge(mem[addra], dina, wea);
            dout_q     <= merge(mem[addra], dina, wea);
            if (wea == 4'b0000) begin
                corrupt_q <= corrupt_en && (rd_count == corrupt_at);
                rd_count  <= rd_count + 1;
            end else begin
                corrupt_q <= 1'b0;
            end
        end
    end

    assign douta = dout_q ^ (corrupt_q ? 32'h00FF_0000 : 32'h0000_0000);

    // ---------------- monitors ----------------
    int cyc = 0;
    int ena_cnt = 0;
    int done_cnt = 0;
    always @(posedge clka) begin
        cyc <= cyc + 1;
        if (ena) ena_cnt <= ena_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_mem [0:8191];
    logic [7:0]  stim_q[$];
    logic [31:0] exp_sum_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    logic [12:0] chk_addr_q[$];

    task automatic preload(input logic [12:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        exp_mem[a] = d;
        @(posedge clka); #1;
        pre_we = 1'b0;
    endtask

    task automatic run_job(input logic [12:0] base, input int len, input bit gaps,
                           input bit exp_err);
        logic [31:0] esum;
        logic [12:0] a;
        logic [31:0] got_sum;
        logic        got_err;
        int          lat;
        int          idx;
        int          t_ref;
        int          waited;
        bit          hs;
        bit          seen;
        esum = '0;
        for (int b = 0; b < len; b++) begin
            a = base + 13'(b / 4);
            exp_mem[a][(b % 4)*8 +: 8] = stim_q[b];
            if (b % 4 == 0) chk_addr_q.push_back(a);
            esum = esum + 32'(stim_q[b]);
        end
        exp_sum_q.push_back(esum);
        exp_err_q.push_back(exp_err);
        exp_lat_q.push_back((len == 0) ? 2 : ((len + 3) / 4) + 3);

        start     = 1'b1;
        base_addr = base;
        byte_len  = 16'(len);
        t_ref     = cyc;
        @(posedge clka); #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end

        idx = 0;
        waited = 0;
        while (idx < len && waited < 400) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = s_valid ? stim_q[idx] : 8'($urandom);
            @(negedge clka);
            hs = s_valid && s_ready;
            if (hs) t_ref = cyc;
            @(posedge clka); #1;
            if (hs) idx++;
            waited++;
        end
        s_valid = 1'b0;
        if (idx < len) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: accepted %0d want %0d", idx, len);
        end

        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clka);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        lat     = cyc - t_ref;
        got_sum = sum;
        got_err = error;
        esum    = exp_sum_q.pop_front();
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: no done within 100 cycles");
            void'(exp_err_q.pop_front());
            void'(exp_lat_q.pop_front());
        end else begin
            if (lat !== exp_lat_q[0]) begin
                n_err++;
                $display("FAIL done_latency: got %0d want %0d", lat, exp_lat_q[0]);
            end
            void'(exp_lat_q.pop_front());
            n_vec++;
            if (got_sum !== esum) begin
                n_err++;
                $display("FAIL sum: got %h want %h", got_sum, esum);
            end
            n_vec++;
            if (got_err !== exp_err_q[0]) begin
                n_err++;
                $display("FAIL error_flag: got %b want %b", got_err, exp_err_q[0]);
            end
            void'(exp_err_q.pop_front());
            @(negedge clka);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL done_pulse: done %b busy %b want 0 0", done, busy);
            end
        end
        while (chk_addr_q.size() > 0) begin
            a = chk_addr_q.pop_front();
            n_vec++;
            if (mem[a] !== exp_mem[a]) begin
                n_err++;
                $display("FAIL mem[%h]: got %h want %h", a, mem[a], exp_mem[a]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rsta      = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        byte_len  = '0;
        s_data    = '0;
        s_valid   = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            pre_we   = 1'b1;
            pre_addr = 13'(i);
            pre_data = '0;
            exp_mem[i] = '0;
            @(posedge clka); #1;
        end
        pre_we = 1'b0;
        @(negedge clka);
        n_vec++;
        if ({s_ready, busy, done, error, ena} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000", {s_ready, busy, done, error, ena});
        end
        n_vec++;
        if (sum !== 32'h0 || wea !== 4'h0) begin
            n_err++;
            $display("FAIL reset_sum_wea: sum %h wea %h want 0 0", sum, wea);
        end
        n_vec++;
        if (addra !== 13'h0 || dina !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr_data: addra %h dina %h want 0 0", addra, dina);
        end
        s_valid = 1'b0;
        @(posedge clka); #1;
        rsta = 1'b0;
        @(posedge clka); #1;
    endtask

    task automatic test_basic();
        stim_q.delete();
        for (int i = 1; i <= 8; i++) stim_q.push_back(8'(i));
        run_job(13'h0010, 8, 1'b0, 1'b0);
    endtask

    task automatic test_partial_word();
        preload(13'h0021, 32'h1122_3344);
        stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_job(13'h0020, 5, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(8'(8'h10 + i));
        run_job(13'h1FFF, 8, 1'b0, 1'b0);
    endtask

    task automatic test_corrupt();
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
        corrupt_at = rd_count;
        corrupt_en = 1'b1;
        run_job(13'h0040, 8, 1'b1, 1'b1);
        corrupt_en = 1'b0;
    endtask

    task automatic test_zero_len();
        int ena_before;
        stim_q.delete();
        ena_before = ena_cnt;
        run_job(13'h0055, 0, 1'b0, 1'b0);
        n_vec++;
        if (ena_cnt !== ena_before) begin
            n_err++;
            $display("FAIL zero_len_ena: got %0d pulses want 0", ena_cnt - ena_before);
        end
    endtask

    task automatic test_abort();
        int n;
        int done_before;
        start     = 1'b1;
        base_addr = 13'h0100;
        byte_len  = 16'd8;
        @(posedge clka); #1;
        start   = 1'b0;
        n       = 0;
        s_valid = 1'b1;
        s_data  = 8'h01;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clka);
            if (s_valid && s_ready) n++;
            @(posedge clka); #1;
            s_data = 8'(n + 1);
        end
        n_vec++;
        if (ena !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: ena %b want 1", ena);
        end
        done_before = done_cnt;
        rsta = 1'b1;
        #1;
        n_vec++;
        if ({ena, wea, s_ready, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL abort_drop: ena %b wea %b s_ready %b busy %b want 0", ena, wea, s_ready, busy);
        end
        s_valid = 1'b0;
        @(posedge clka); #1;
        @(posedge clka); #1;
        rsta = 1'b0;
        for (int i = 0; i < 20; i++) @(posedge clka);
        #1;
        n_vec++;
        if (done_cnt !== done_before) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - done_before);
        end
    endtask

    task automatic test_after_abort();
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        run_job(13'h0200, 6, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_word();
        test_wrap();
        test_corrupt();
        test_zero_len();
        test_abort();
        test_after_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
